// File: rtl/fix_mac.sv
`default_nettype none
// ==========================================================================
// fix_mac : pipelined signed fixed-point multiply-accumulate with a single
//           round-and-saturate per ACC_LEN-beat window, valid/ready on both sides
// Rev 1.0
// ==========================================================================
module fix_mac #(
  parameter int WIDTH       = 16,
  parameter int POINT_WIDTH = 8,
  parameter int ACC_LEN     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  localparam int ACC_W = 2*WIDTH + $clog2(ACC_LEN) + 1;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int EXT_W = ACC_W - 2*WIDTH;
  localparam logic [CNT_W-1:0]        c_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic signed [ACC_W-1:0] c_HALF = ACC_W'(1) << (POINT_WIDTH - 1);

  logic [CNT_W-1:0]          r_cnt;
  logic                      r_s1_valid, r_s1_first, r_s1_last;
  logic signed [WIDTH-1:0]   r_s1_a, r_s1_b, r_s1_bias;
  logic                      r_s2_valid, r_s2_first, r_s2_last;
  logic signed [2*WIDTH-1:0] r_s2_prod;
  logic signed [WIDTH-1:0]   r_s2_bias;
  logic                      r_s3_valid, r_s3_last;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_s4_valid;
  logic signed [ACC_W-1:0]   r_s4_rnd;
  logic                      r_out_valid;
  logic [WIDTH-1:0]          r_out_data;
  logic                      r_out_sat;

  logic                      w_en, w_accept;
  logic signed [ACC_W-1:0]   w_prod_ext, w_bias_ext, w_rnd;
  logic                      w_sat_hi, w_sat_lo;

  // A pending, unaccepted result freezes every stage so nothing is lost.
  assign w_en      = !(r_out_valid && !out_ready);
  assign in_ready  = !rst && w_en;
  assign w_accept  = in_valid && in_ready;

  assign w_prod_ext = {{EXT_W{r_s2_prod[2*WIDTH-1]}}, r_s2_prod};
  assign w_bias_ext = {{(ACC_W-WIDTH){r_s2_bias[WIDTH-1]}}, r_s2_bias} << POINT_WIDTH;
  assign w_rnd      = (r_acc + c_HALF) >>> POINT_WIDTH;

  // Result fits only when every bit from the sign down to bit WIDTH-1 agrees.
  assign w_sat_hi = !r_s4_rnd[ACC_W-1] && (|r_s4_rnd[ACC_W-2:WIDTH-1]);
  assign w_sat_lo =  r_s4_rnd[ACC_W-1] && !(&r_s4_rnd[ACC_W-2:WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_bias  <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_bias  <= in_bias;
        r_s1_first <= (r_cnt == '0);
        r_s1_last  <= (r_cnt == c_LAST);
        r_cnt      <= (r_cnt == c_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_bias  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_prod  <= (2*WIDTH)'(r_s1_a) * (2*WIDTH)'(r_s1_b);
      r_s2_bias  <= r_s1_bias;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_acc      <= '0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      if (r_s2_valid) begin
        r_acc <= r_s2_first ? (w_bias_ext + w_prod_ext) : (r_acc + w_prod_ext);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s4_valid <= 1'b0;
      r_s4_rnd   <= '0;
    end else if (w_en) begin
      r_s4_valid <= r_s3_valid && r_s3_last;
      if (r_s3_valid && r_s3_last) begin
        r_s4_rnd <= w_rnd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s4_valid;
      if (r_s4_valid) begin
        r_out_sat <= w_sat_hi || w_sat_lo;
        if (w_sat_hi) begin
          r_out_data <= {1'b0, {(WIDTH-1){1'b1}}};
        end else if (w_sat_lo) begin
          r_out_data <= {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          r_out_data <= r_s4_rnd[WIDTH-1:0];
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_fix_mac.sv
`default_nettype none
// ==========================================================================
// tb_fix_mac : directed + randomized bench for fix_mac (Q8.8, 3-beat windows)
// Rev 1.0
// ==========================================================================
module tb_fix_mac;
  localparam int W  = 16;
  localparam int PW = 8;
  localparam int N  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0, in_bias = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_sat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } res_t;

  res_t   exp_q[$];
  int     hs_cyc[$];
  longint m_sum;
  int     m_cnt;
  bit     rand_rdy = 1'b0;

  fix_mac #(.WIDTH(W), .POINT_WIDTH(PW), .ACC_LEN(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_bias  (in_bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer sum, then floor((sum + half) / 2^PW) and clamp.
  function automatic longint floor_div(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] bias);
    longint sa, sb, sbias, r;
    res_t   e;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    sbias = longint'($signed(bias));
    if (m_cnt == 0) m_sum = sbias * (64'sd1 << PW);
    m_sum = m_sum + sa * sb;
    m_cnt++;
    if (m_cnt == N) begin
      r = floor_div(m_sum + (64'sd1 << (PW - 1)), 64'sd1 << PW);
      if (r > 32767) begin
        e.d = 16'h7FFF; e.s = 1'b1;
      end else if (r < -32768) begin
        e.d = 16'h8000; e.s = 1'b1;
      end else begin
        e.d = 16'(r); e.s = 1'b0;
      end
      exp_q.push_back(e);
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
  endtask

  // Present a beat and hold it until the DUT takes it; leaves in_valid high.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] bias);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    in_a = a; in_b = b; in_bias = bias; in_valid = 1'b1;
    while (!ok && n < 200) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
      @(posedge clk); #1;
    end
    if (ok) model_beat(a, b, bias);
    else chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0; rand_rdy = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] rv();
    if ($urandom_range(0, 1) == 0) return W'($urandom_range(0, 65535));
    return W'(int'($urandom_range(0, 2048)) - 1024);
  endfunction

  // Scoreboard: every completed handshake must match the next model result.
  res_t m_e;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(m_e.d));
        chk("out_sat", 32'(out_sat), 32'(m_e.s));
        hs_cyc.push_back(cyc);
      end
    end
  end

  logic [W-1:0] cap_d;
  logic         cap_s;
  int           lat;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1.0 + 3 * (1.5 * 2.0) = 10.0, with latency measurement
    send_beat(16'h0180, 16'h0200, 16'h0100);
    send_beat(16'h0180, 16'h0200, 16'h0100);
    send_beat(16'h0180, 16'h0200, 16'h0100);
    in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd4);
    @(posedge clk); #1;
    drain();

    // 1.5 LSB rounds up to 2
    for (int k = 0; k < N; k++) send_beat(16'h0001, 16'h0080, 16'h0000);
    drain();

    // positive then negative saturation
    for (int k = 0; k < N; k++) send_beat(16'h7FFF, 16'h7FFF, 16'h0000);
    for (int k = 0; k < N; k++) send_beat(16'hFF00, 16'h7F00, 16'h0000);
    drain();

    // two back-to-back windows; bias on non-first beats must be ignored
    hs_cyc.delete();
    send_beat(16'h0100, 16'h0300, 16'h0200);
    send_beat(16'hFE00, 16'h0080, 16'h7000);
    send_beat(16'h0040, 16'h0400, 16'h7000);
    send_beat(16'h0020, 16'hFF00, 16'hFC00);
    send_beat(16'h0200, 16'h0200, 16'h1234);
    send_beat(16'h0001, 16'h0001, 16'h4321);
    drain();
    chk("b2b_count", 32'(hs_cyc.size()), 32'd2);
    if (hs_cyc.size() == 2) chk("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'(N));

    // downstream stall with a pending upstream beat
    out_ready = 1'b0;
    send_beat(16'h0300, 16'h0100, 16'hFF80);
    send_beat(16'h0010, 16'hFFF0, 16'h0000);
    send_beat(16'h0200, 16'h0180, 16'h0000);
    in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("stall_result_seen", 32'(out_valid), 32'd1);
    cap_d = out_data;
    cap_s = out_sat;
    @(posedge clk); #1;
    in_a = 16'h0111; in_b = 16'h0222; in_bias = 16'h0033; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(cap_d));
      chk("stall_sat", 32'(out_sat), 32'(cap_s));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(16'h0111, 16'h0222, 16'h0033);
    send_beat(16'h0F00, 16'h0100, 16'h0000);
    send_beat(16'hF000, 16'h0010, 16'h0000);
    drain();

    // reset after two beats discards the partial window
    send_beat(16'h1000, 16'h1000, 16'h0400);
    send_beat(16'h1000, 16'h1000, 16'h0400);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_sat", 32'(out_sat), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    send_beat(16'h0080, 16'h0300, 16'h0050);
    send_beat(16'hFF80, 16'h0100, 16'h0000);
    send_beat(16'h0100, 16'h0100, 16'h0000);
    drain();

    // randomized windows with input gaps and random backpressure
    rand_rdy = 1'b1;
    for (int w = 0; w < 20; w++) begin
      logic [W-1:0] bias;
      bias = rv();
      for (int k = 0; k < N; k++) begin
        send_beat(rv(), rv(), (k == 0) ? bias : rv());
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    drain();
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("no_extra_results", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
